// File: rtl/cpu_pkg.sv
// Shared pipeline types for the CPU: stage-entry record, zero register and bubble entry.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE_ENTRY = '{valid: 1'b0, rd: ZERO_REG, regwrite: 1'b0, memread: 1'b0};

    // True when a source operand is actually read and names the given register.
    function automatic logic src_match(
        input logic             uses,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] rd
    );
        return uses && (src == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments when enabled and holds once it reaches all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count register; asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Shadows EX/MEM/WB destination state for the forwarding unit, detects
// load-use hazards (one-cycle stall + bubble), squashes on flush, counts stalls.
module hazard_tracker #(
    parameter int               REG_W    = cpu_pkg::REG_W,
    parameter logic [REG_W-1:0] ZERO_REG = cpu_pkg::ZERO_REG,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [REG_W-1:0] Rd_ID_EX,
    output logic             ID_EX_MemRead,
    output logic [REG_W-1:0] Rd_EX_MEM,
    output logic             EX_MEM_RegWrite,
    output logic [REG_W-1:0] Rd_MEM_WB,
    output logic             MEM_WB_RegWrite,
    output logic [CNT_W-1:0] stall_count
);

    localparam cpu_pkg::stage_entry_t BUBBLE = '{valid: 1'b0, rd: ZERO_REG, regwrite: 1'b0, memread: 1'b0};

    cpu_pkg::stage_entry_t ex_r;
    cpu_pkg::stage_entry_t mem_r;
    cpu_pkg::stage_entry_t wb_r;
    cpu_pkg::stage_entry_t ex_next_s;
    logic                  hazard_s;

    // Load in EX whose result a real ID instruction needs next cycle; XZR never conflicts.
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid && ex_r.valid && ex_r.memread && ex_r.regwrite && (ex_r.rd != ZERO_REG)) begin
            hazard_s = cpu_pkg::src_match(id_uses_rn, id_rn, ex_r.rd)
                    || cpu_pkg::src_match(id_uses_rm, id_rm, ex_r.rd);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flushed consumer is discarded anyway, so flush suppresses the stall.
    assign stall  = hazard_s && !flush;
    assign bubble = stall || flush || !id_valid;

    // Next EX entry: bubble or the instruction currently in ID.
    always_comb begin
        ex_next_s = BUBBLE;
        if (bubble) begin
            ex_next_s = BUBBLE;
        end else begin
            ex_next_s = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
        end
    end

    // Stage shift register; reset loads the bubble entry everywhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r  <= BUBBLE;
            mem_r <= BUBBLE;
            wb_r  <= BUBBLE;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    assign Rd_ID_EX        = ex_r.rd;
    assign ID_EX_MemRead   = ex_r.valid && ex_r.memread;
    assign Rd_EX_MEM       = mem_r.rd;
    assign EX_MEM_RegWrite = mem_r.valid && mem_r.regwrite;
    assign Rd_MEM_WB       = wb_r.rd;
    assign MEM_WB_RegWrite = wb_r.valid && wb_r.regwrite;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (stall),
        .count(stall_count)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: directed vectors push expectations, a monitor checks them.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread, flush;
    logic [4:0] id_rn, id_rm, id_rd;

    logic        stall, bubble, id_ex_mr, ex_mem_rw, mem_wb_rw;
    logic [4:0]  rd_id_ex, rd_ex_mem, rd_mem_wb;
    logic [15:0] stall_count;

    logic        stall4, bubble4, id_ex_mr4, ex_mem_rw4, mem_wb_rw4;
    logic [4:0]  rd_id_ex4, rd_ex_mem4, rd_mem_wb4;
    logic [3:0]  stall_count4;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .bubble(bubble), .Rd_ID_EX(rd_id_ex), .ID_EX_MemRead(id_ex_mr),
        .Rd_EX_MEM(rd_ex_mem), .EX_MEM_RegWrite(ex_mem_rw), .Rd_MEM_WB(rd_mem_wb),
        .MEM_WB_RegWrite(mem_wb_rw), .stall_count(stall_count)
    );

    hazard_tracker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall4), .bubble(bubble4), .Rd_ID_EX(rd_id_ex4), .ID_EX_MemRead(id_ex_mr4),
        .Rd_EX_MEM(rd_ex_mem4), .EX_MEM_RegWrite(ex_mem_rw4), .Rd_MEM_WB(rd_mem_wb4),
        .MEM_WB_RegWrite(mem_wb_rw4), .stall_count(stall_count4)
    );

    typedef struct {
        int          id;
        logic        stall;
        logic        bubble;
        logic [4:0]  rd_idex;
        logic        idex_mr;
        logic [4:0]  rd_exmem;
        logic        exmem_rw;
        logic [4:0]  rd_memwb;
        logic        memwb_rw;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        logic        chk_regs;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    // Drive one ID-stage instruction just after the falling edge.
    task automatic ins(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
        @(negedge clk);
        #1;
        id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
        id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    task automatic nop();
        ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the hand-computed expectation for the current cycle and wake the monitor.
    task automatic expect_all(input logic st, input logic bb,
                              input logic [4:0] a, input logic am,
                              input logic [4:0] b, input logic bw,
                              input logic [4:0] c, input logic cw,
                              input int cnt, input logic regs);
        exp_t e;
        e.id = vec_id; vec_id++;
        e.stall = st; e.bubble = bb;
        e.rd_idex = a; e.idex_mr = am; e.rd_exmem = b; e.exmem_rw = bw;
        e.rd_memwb = c; e.memwb_rw = cw;
        e.cnt = 16'(cnt);
        e.cnt4 = (cnt > 15) ? 4'd15 : 4'(cnt);
        e.chk_regs = regs;
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    // Monitor: pops one expectation per sample event and compares against both DUTs.
    initial begin
        forever begin
            exp_t e;
            logic ok;
            @(sample_ev);
            #1;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: sample with no expectation queued");
            end else begin
                e = sb_q.pop_front();
                ok = (stall === e.stall) && (bubble === e.bubble) && (stall_count === e.cnt)
                  && (stall4 === e.stall) && (stall_count4 === e.cnt4);
                if (e.chk_regs) begin
                    ok = ok && (rd_id_ex === e.rd_idex) && (id_ex_mr === e.idex_mr)
                            && (rd_ex_mem === e.rd_exmem) && (ex_mem_rw === e.exmem_rw)
                            && (rd_mem_wb === e.rd_memwb) && (mem_wb_rw === e.memwb_rw);
                end
                if (!ok) begin
                    fails++;
                    $display("FAIL vec%0d: actual st=%0b bb=%0b idex=%0d/%0b exmem=%0d/%0b memwb=%0d/%0b cnt=%0d cnt4=%0d | required st=%0b bb=%0b idex=%0d/%0b exmem=%0d/%0b memwb=%0d/%0b cnt=%0d cnt4=%0d",
                             e.id, stall, bubble, rd_id_ex, id_ex_mr, rd_ex_mem, ex_mem_rw,
                             rd_mem_wb, mem_wb_rw, stall_count, stall_count4,
                             e.stall, e.bubble, e.rd_idex, e.idex_mr, e.rd_exmem, e.exmem_rw,
                             e.rd_memwb, e.memwb_rw, e.cnt, e.cnt4);
                end
            end
        end
    end

    initial begin
        id_valid = 1'b0; id_rn = 5'd0; id_rm = 5'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        id_rd = 5'd31; id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;

        // Reset held with random ID inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            id_valid = 1'($urandom_range(0, 1)); id_rn = 5'($urandom_range(0, 31));
            id_rm = 5'($urandom_range(0, 31)); id_uses_rn = 1'($urandom_range(0, 1));
            id_uses_rm = 1'($urandom_range(0, 1)); id_rd = 5'($urandom_range(0, 31));
            id_regwrite = 1'($urandom_range(0, 1)); id_memread = 1'($urandom_range(0, 1));
            flush = 1'($urandom_range(0, 1));
            expect_all(1'b0, flush || !id_valid, 5'd31, 1'b0, 5'd31, 1'b0, 5'd31, 1'b0, 0, 1'b1);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        id_valid = 1'b0; id_uses_rn = 1'b0; id_uses_rm = 1'b0; id_regwrite = 1'b0;
        id_memread = 1'b0; flush = 1'b0; id_rd = 5'd31;
        expect_all(1'b0, 1'b1, 5'd31, 1'b0, 5'd31, 1'b0, 5'd31, 1'b0, 0, 1'b1);

        // Load-use: LDUR X2 then ADD X3,X2,X4
        ins(1, 1, 0, 1, 0, 2, 1, 1, 0);   expect_all(0, 0, 31, 0, 31, 0, 31, 0, 0, 1);
        ins(1, 2, 4, 1, 1, 3, 1, 0, 0);   expect_all(1, 1, 2, 1, 31, 0, 31, 0, 0, 1);
        ins(1, 2, 4, 1, 1, 3, 1, 0, 0);   expect_all(0, 0, 31, 0, 2, 1, 31, 0, 1, 1);
        nop();                            expect_all(0, 1, 3, 0, 31, 0, 2, 1, 1, 1);

        // No false hazard: load to XZR, then non-load producer
        ins(1, 1, 0, 1, 0, 31, 1, 1, 0);  expect_all(0, 0, 31, 0, 3, 1, 31, 0, 1, 1);
        ins(1, 31, 31, 1, 1, 6, 1, 0, 0); expect_all(0, 0, 31, 1, 31, 0, 3, 1, 1, 1);
        ins(1, 1, 1, 1, 1, 5, 1, 0, 0);   expect_all(0, 0, 6, 0, 31, 1, 31, 0, 1, 1);
        ins(1, 5, 0, 1, 0, 7, 1, 0, 0);   expect_all(0, 0, 5, 0, 6, 1, 31, 1, 1, 1);

        // Flush priority over a load-use on Rm
        ins(1, 1, 0, 1, 0, 8, 1, 1, 0);   expect_all(0, 0, 7, 0, 5, 1, 6, 1, 1, 1);
        ins(1, 0, 8, 0, 1, 9, 1, 0, 1);   expect_all(0, 1, 8, 1, 7, 1, 5, 1, 1, 1);
        nop();                            expect_all(0, 1, 31, 0, 8, 1, 7, 1, 1, 1);

        // Pipeline shift: ADD X1, SUB X2, ORR X3
        ins(1, 4, 5, 1, 1, 1, 1, 0, 0);   expect_all(0, 0, 31, 0, 31, 0, 8, 1, 1, 1);
        ins(1, 6, 7, 1, 1, 2, 1, 0, 0);   expect_all(0, 0, 1, 0, 31, 0, 31, 0, 1, 1);
        ins(1, 1, 2, 1, 1, 3, 1, 0, 0);   expect_all(0, 0, 2, 0, 1, 1, 31, 0, 1, 1);
        nop();                            expect_all(0, 1, 3, 0, 2, 1, 1, 1, 1, 1);

        // Back-to-back loads to X10, consumer on Rm only (Rn match ignored)
        ins(1, 1, 0, 1, 0, 10, 1, 1, 0);  expect_all(0, 0, 31, 0, 3, 1, 2, 1, 1, 1);
        ins(1, 1, 0, 1, 0, 10, 1, 1, 0);  expect_all(0, 0, 10, 1, 31, 0, 3, 1, 1, 1);
        ins(1, 10, 10, 0, 1, 11, 1, 0, 0); expect_all(1, 1, 10, 1, 10, 1, 31, 0, 1, 1);
        ins(1, 10, 10, 0, 1, 11, 1, 0, 0); expect_all(0, 0, 31, 0, 10, 1, 10, 1, 2, 1);

        // Unused sources matching a load do not stall
        ins(1, 1, 0, 1, 0, 12, 1, 1, 0);  expect_all(0, 0, 11, 0, 31, 0, 10, 1, 2, 1);
        ins(1, 12, 12, 0, 0, 31, 0, 0, 0); expect_all(0, 0, 12, 1, 11, 1, 31, 0, 2, 1);

        // Saturation: LDUR X2,[X2] held stalls every other cycle
        for (int i = 0; i < 44; i++) begin
            ins(1, 2, 0, 1, 0, 2, 1, 1, 0);
            expect_all(1'(i % 2), 1'(i % 2), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2 + i / 2, 1'b0);
        end

        // Reset asserted mid-stall clears everything within the cycle
        #2;
        reset = 1'b0;
        expect_all(0, 0, 31, 0, 31, 0, 31, 0, 0, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        id_valid = 1'b0; id_uses_rn = 1'b0; id_uses_rm = 1'b0; id_regwrite = 1'b0;
        id_memread = 1'b0; id_rd = 5'd31;
        expect_all(0, 1, 31, 0, 31, 0, 31, 0, 0, 1);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
